// File: rtl/vga_cfg_pkg.sv
// Shared types and constants for the VGA mode controller: command and FSM
// state encodings plus the brightness/scroll helpers.
package vga_cfg_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_NEXT   = 3'd1,
    CMD_PREV   = 3'd2,
    CMD_BRIGHT = 3'd3,
    CMD_SCROLL = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  localparam logic [2:0] BRIGHT_MAX   = 3'd7;
  localparam logic [9:0] H_ACTIVE_DEF = 10'd640;

  // Fixed priority S > D > F > G; lower-priority simultaneous presses are dropped.
  function automatic cmd_e key_prio(input logic s, input logic d, input logic f, input logic g);
    cmd_e c;
    if (s) begin
      c = CMD_NEXT;
    end else if (d) begin
      c = CMD_PREV;
    end else if (f) begin
      c = CMD_BRIGHT;
    end else if (g) begin
      c = CMD_SCROLL;
    end else begin
      c = CMD_NONE;
    end
    return c;
  endfunction

  function automatic logic [9:0] scroll_next(input logic [9:0] off, input logic [9:0] step,
                                             input logic [9:0] modulus);
    logic [10:0] sum;
    sum = {1'b0, off} + {1'b0, step};
    if (sum >= {1'b0, modulus}) begin
      sum = sum - {1'b0, modulus};
    end else begin
      sum = sum;
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/key_filter.sv
// One push-button channel: double-flop synchroniser, stable-time debounce and
// a single-cycle strobe on each debounced press (filtered 1->0 edge).
module key_filter #(
  parameter logic [19:0] CNT_MAX = 20'd999_999
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        filt_q, filt_d;
  logic        press_q, press_d;
  logic [19:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= 20'd0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any glitch back to the filtered level restarts the stable-time count.
  always_comb begin
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    press_d = 1'b0;
    if (sync2_q == filt_q) begin
      cnt_d = 20'd0;
    end else if (cnt_q == CNT_MAX - 20'd1) begin
      cnt_d   = 20'd0;
      filt_d  = sync2_q;
      press_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/vga_mode_ctrl.sv
// Key-driven display configuration: commands are latched on a press and applied
// only at frame_start. Optional auto pattern cycling under VGA_MODE_AUTO_CYCLE_EN.
module vga_mode_ctrl
  import vga_cfg_pkg::*;
#(
  parameter logic [19:0] CNT_MAX     = 20'd999_999,
  parameter logic [2:0]  NUM_PAT     = 3'd4,
  parameter logic [9:0]  H_ACTIVE    = H_ACTIVE_DEF,
  parameter logic [9:0]  SCROLL_STEP = 10'd4,
  parameter logic [7:0]  AUTO_FRAMES = 8'd120
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_s,
  input  logic       key_d,
  input  logic       key_f,
  input  logic       key_g,
  input  logic       frame_start,
  output logic [2:0] pat_sel,
  output logic [2:0] bright,
  output logic [9:0] scroll_off,
  output logic       scroll_en,
  output logic       cfg_upd
);

  logic [3:0] keys_n_s, press_s;
  cmd_e       cmd_now_s, cmd_q, cmd_d;
  state_e     state_q, state_d;
  logic       apply_s, auto_fire_s;
  logic [2:0] pat_q, pat_d, pat_inc_s, bright_q, bright_d;
  logic [9:0] off_q, off_d;
  logic       en_q, en_d, upd_q, upd_d;

  assign keys_n_s = {key_s, key_d, key_f, key_g};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_filter #(.CNT_MAX(CNT_MAX)) u_key_filter (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .key_n_i (keys_n_s[i]),
      .press_o (press_s[i])
    );
  end

  assign cmd_now_s = key_prio(press_s[3], press_s[2], press_s[1], press_s[0]);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_NONE;
      pat_q    <= 3'd0;
      bright_q <= BRIGHT_MAX;
      off_q    <= 10'd0;
      en_q     <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      pat_q    <= pat_d;
      bright_q <= bright_d;
      off_q    <= off_d;
      en_q     <= en_d;
      upd_q    <= upd_d;
    end
  end

  // The register update happens on the edge that leaves PENDING, so the APPLY
  // cycle already shows the new value together with cfg_upd.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    apply_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_now_s != CMD_NONE) begin
          cmd_d   = cmd_now_s;
          state_d = ST_PENDING;
        end else begin
          cmd_d = CMD_NONE;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          state_d = ST_APPLY;
          apply_s = 1'b1;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NONE;
      end
    endcase
  end

`ifdef VGA_MODE_AUTO_CYCLE_EN
  logic       any_strobe_s;
  logic [7:0] afc_q, afc_d;

  assign any_strobe_s = |press_s;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      afc_q <= 8'd0;
    end else begin
      afc_q <= afc_d;
    end
  end

  always_comb begin
    afc_d       = afc_q;
    auto_fire_s = 1'b0;
    if (any_strobe_s) begin
      afc_d = 8'd0;
    end else if (frame_start && (state_q == ST_IDLE)) begin
      if (afc_q == AUTO_FRAMES - 8'd1) begin
        afc_d       = 8'd0;
        auto_fire_s = 1'b1;
      end else begin
        afc_d = afc_q + 8'd1;
      end
    end else begin
      afc_d = afc_q;
    end
  end
`else
  logic [7:0] unused_auto_frames_s;
  assign unused_auto_frames_s = AUTO_FRAMES;
  assign auto_fire_s          = 1'b0;
`endif

  assign pat_inc_s = (pat_q == NUM_PAT - 3'd1) ? 3'd0 : pat_q + 3'd1;

  // Scroll advance uses the pre-apply scroll_en, independent of the command FSM.
  always_comb begin
    pat_d    = pat_q;
    bright_d = bright_q;
    en_d     = en_q;
    off_d    = off_q;
    upd_d    = 1'b0;
    if (apply_s) begin
      upd_d = 1'b1;
      case (cmd_q)
        CMD_NEXT:   pat_d    = pat_inc_s;
        CMD_PREV:   pat_d    = (pat_q == 3'd0) ? NUM_PAT - 3'd1 : pat_q - 3'd1;
        CMD_BRIGHT: bright_d = (bright_q == 3'd0) ? BRIGHT_MAX : bright_q - 3'd1;
        CMD_SCROLL: en_d     = ~en_q;
        default:    pat_d    = pat_q;
      endcase
    end else if (auto_fire_s) begin
      upd_d = 1'b1;
      pat_d = pat_inc_s;
    end else begin
      pat_d = pat_q;
    end
    if (frame_start && en_q) begin
      off_d = scroll_next(off_q, SCROLL_STEP, H_ACTIVE);
      upd_d = 1'b1;
    end else begin
      off_d = off_q;
    end
  end

  assign pat_sel    = pat_q;
  assign bright     = bright_q;
  assign scroll_off = off_q;
  assign scroll_en  = en_q;
  assign cfg_upd    = upd_q;

endmodule
